// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: response codes, FSM state types and address helper shared by the
// AXI4-Lite register bank and its decoder.
package axi_lite_pkg;
    typedef enum logic [1:0] {OKAY = 2'b00, SLVERR = 2'b10} resp_t;
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;

    function automatic int addr_lsb(input int data_w);
        return $clog2(data_w / 8);
    endfunction
endpackage

// File: rtl/axi_lite_decode.sv
// axi_lite_decode: maps a byte address onto a register index and flags whether it
// lands on an aligned register inside the bank.
module axi_lite_decode
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int NUM_REGS = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int IDX_W = $clog2(NUM_REGS)
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [IDX_W-1:0]  idx,
    output logic              valid
);
    localparam int LSB = addr_lsb(DATA_W);

    logic [ADDR_W-1:0] off;

    assign off = addr - BASE_ADDR;
    assign idx = off[LSB +: IDX_W];
    assign valid = addr >= BASE_ADDR && off[LSB-1:0] == '0 && (off >> LSB) < ADDR_W'(NUM_REGS);
endmodule

// File: rtl/axi_lite_slave_regs.sv
// axi_lite_slave_regs: AXI4-Lite register bank with byte strobes, a read-only mask,
// independent AW/W acceptance and one-cycle registered reads.
module axi_lite_slave_regs
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int NUM_REGS = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       awvalid,
    output logic                       awready,
    input  logic [ADDR_W-1:0]          awaddr,
    input  logic [2:0]                 awprot,
    input  logic                       wvalid,
    output logic                       wready,
    input  logic [DATA_W-1:0]          wdata,
    input  logic [DATA_W/8-1:0]        wstrb,
    output logic                       bvalid,
    input  logic                       bready,
    output logic [1:0]                 bresp,
    input  logic                       arvalid,
    output logic                       arready,
    input  logic [ADDR_W-1:0]          araddr,
    input  logic [2:0]                 arprot,
    output logic                       rvalid,
    input  logic                       rready,
    output logic [DATA_W-1:0]          rdata,
    output logic [1:0]                 rresp,
    output logic [NUM_REGS*DATA_W-1:0] reg_q
);
    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W = $clog2(NUM_REGS);

    wr_state_t         w_state_q, w_state_d;
    rd_state_t         r_state_q, r_state_d;
    resp_t             bresp_q, bresp_d, rresp_q, rresp_d;
    logic              en_q;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [IDX_W-1:0]  w_idx, r_idx;
    logic              w_addr_ok, r_addr_ok, w_ok, commit;
    logic              aw_hs, w_hs, ar_hs;
    logic              unused_prot;

    assign unused_prot = ^{awprot, arprot};

    // Readies stay low until the first edge after reset release
    assign awready = en_q && (w_state_q == W_IDLE || w_state_q == W_DATA);
    assign wready = en_q && (w_state_q == W_IDLE || w_state_q == W_ADDR);
    assign bvalid = w_state_q == W_RESP;
    assign arready = en_q && r_state_q == R_IDLE;
    assign rvalid = r_state_q == R_DATA;
    assign aw_hs = awvalid && awready;
    assign w_hs = wvalid && wready;
    assign ar_hs = arvalid && arready;
    assign bresp = bresp_q;
    assign rresp = rresp_q;
    assign rdata = rdata_q;

    // Address/data muxes pick the live beat so the commit edge sees it directly
    assign awaddr_d = aw_hs ? awaddr : awaddr_q;
    assign wdata_d = w_hs ? wdata : wdata_q;
    assign wstrb_d = w_hs ? wstrb : wstrb_q;

    axi_lite_decode #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .BASE_ADDR(BASE_ADDR), .IDX_W(IDX_W)
    ) u_aw_dec (
        .addr(awaddr_d), .idx(w_idx), .valid(w_addr_ok)
    );

    axi_lite_decode #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .BASE_ADDR(BASE_ADDR), .IDX_W(IDX_W)
    ) u_ar_dec (
        .addr(araddr), .idx(r_idx), .valid(r_addr_ok)
    );

    always_comb begin
        w_state_d = w_state_q;
        case (w_state_q)
            W_IDLE:  w_state_d = aw_hs && w_hs ? W_RESP : aw_hs ? W_ADDR : w_hs ? W_DATA : W_IDLE;
            W_ADDR:  w_state_d = w_hs ? W_RESP : W_ADDR;
            W_DATA:  w_state_d = aw_hs ? W_RESP : W_DATA;
            default: w_state_d = bready ? W_IDLE : W_RESP;
        endcase
    end

    always_comb begin
        commit = w_state_q != W_RESP && w_state_d == W_RESP;
        w_ok = w_addr_ok && !RO_MASK[w_idx];
        bresp_d = commit ? (w_ok ? OKAY : SLVERR) : bresp_q;
        regs_d = regs_q;
        for (int k = 0; k < STRB_W; k++)
            if (commit && w_ok && wstrb_d[k]) regs_d[w_idx][k*8 +: 8] = wdata_d[k*8 +: 8];
    end

    // Reads sample regs_q, so a same-edge write is not yet visible
    always_comb begin
        r_state_d = r_state_q == R_IDLE ? (ar_hs ? R_DATA : R_IDLE) : (rready ? R_IDLE : R_DATA);
        rdata_d = ar_hs ? (r_addr_ok ? regs_q[r_idx] : '0) : rdata_q;
        rresp_d = ar_hs ? (r_addr_ok ? OKAY : SLVERR) : rresp_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_q <= 1'b0;
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            bresp_q <= OKAY;
            rresp_q <= OKAY;
            rdata_q <= '0;
            awaddr_q <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            en_q <= 1'b1;
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            bresp_q <= bresp_d;
            rresp_q <= rresp_d;
            rdata_q <= rdata_d;
            awaddr_q <= awaddr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            regs_q <= regs_d;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign reg_q[g*DATA_W +: DATA_W] = regs_q[g];
    end
endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// tb_axi_lite_slave_regs: directed scoreboard bench driving a default bank and a bank
// with register 0 read-only from the same bus stimulus.
module tb_axi_lite_slave_regs;
    import axi_lite_pkg::*;

    logic clk = 1'b0, rst = 1'b0;
    logic awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic [31:0] awaddr = 0, wdata = 0, araddr = 0;
    logic [3:0] wstrb = 0;
    logic [2:0] awprot = 0, arprot = 0;
    logic awready, wready, bvalid, arready, rvalid;
    logic awready_r, wready_r, bvalid_r, arready_r, rvalid_r;
    logic [1:0] bresp, rresp, bresp_r, rresp_r;
    logic [31:0] rdata, rdata_r;
    logic [511:0] reg_q, reg_q_r;

    int checks = 0, errors = 0;
    logic [31:0] mem [16];
    logic [31:0] mem_r [16];
    logic [1:0] exp_b[$], exp_b_r[$];
    logic [33:0] exp_r[$], exp_r_r[$];

    always #5 clk = ~clk;

    axi_lite_slave_regs dut (
        .clk(clk), .rst(rst), .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .bvalid(bvalid), .bready(bready),
        .bresp(bresp), .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .reg_q(reg_q)
    );

    axi_lite_slave_regs #(.RO_MASK(16'h0001)) dut_ro (
        .clk(clk), .rst(rst), .awvalid(awvalid), .awready(awready_r), .awaddr(awaddr), .awprot(awprot),
        .wvalid(wvalid), .wready(wready_r), .wdata(wdata), .wstrb(wstrb), .bvalid(bvalid_r), .bready(bready),
        .bresp(bresp_r), .arvalid(arvalid), .arready(arready_r), .araddr(araddr), .arprot(arprot),
        .rvalid(rvalid_r), .rready(rready), .rdata(rdata_r), .rresp(rresp_r), .reg_q(reg_q_r)
    );

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] flat(input bit ro);
        logic [511:0] f;
        for (int i = 0; i < 16; i++) f[i*32 +: 32] = ro ? mem_r[i] : mem[i];
        return f;
    endfunction

    function automatic bit addr_ok(input logic [31:0] a);
        return a[1:0] == 2'b00 && a < 32'd64;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 16; i++) begin
            mem[i] = '0;
            mem_r[i] = '0;
        end
    endtask

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int idx;
        bit ok;
        ok = addr_ok(a);
        idx = int'(a[5:2]);
        exp_b.push_back(ok ? OKAY : SLVERR);
        exp_b_r.push_back(ok && idx != 0 ? OKAY : SLVERR);
        for (int k = 0; k < 4; k++) if (ok && s[k]) begin
            mem[idx][k*8 +: 8] = d[k*8 +: 8];
            if (idx != 0) mem_r[idx][k*8 +: 8] = d[k*8 +: 8];
        end
    endtask

    task automatic model_read(input logic [31:0] a);
        bit ok;
        ok = addr_ok(a);
        exp_r.push_back(ok ? {OKAY, mem[a[5:2]]} : {SLVERR, 32'h0});
        exp_r_r.push_back(ok ? {OKAY, mem_r[a[5:2]]} : {SLVERR, 32'h0});
    endtask

    // lead = cycles by which W precedes AW
    task automatic wr_issue(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int lead);
        bit aw_done, w_done, ahs, whs;
        int c;
        aw_done = 0;
        w_done = 0;
        c = 0;
        model_write(a, d, s);
        awaddr = a;
        wdata = d;
        wstrb = s;
        while (!(aw_done && w_done) && c < 20) begin
            @(negedge clk);
            awvalid = !aw_done && c >= lead;
            wvalid = !w_done;
            if (w_done && !aw_done) chk("w_first_ready", {awready, wready}, 2'b10);
            ahs = awvalid && awready;
            whs = wvalid && wready;
            @(posedge clk);
            aw_done |= ahs;
            w_done |= whs;
            c++;
        end
        @(negedge clk);
        awvalid = 0;
        wvalid = 0;
        chk("wr_accept", {aw_done, w_done}, 2'b11);
        chk("b_latency", {bvalid, bvalid_r}, 2'b11);
    endtask

    task automatic b_collect();
        chk("bresp", bresp, exp_b.pop_front());
        chk("bresp_ro", bresp_r, exp_b_r.pop_front());
        bready = 1;
        @(posedge clk);
        @(negedge clk);
        bready = 0;
        chk("b_done", bvalid, 0);
        chk("reg_q", reg_q, flat(0));
        chk("reg_q_ro", reg_q_r, flat(1));
    endtask

    task automatic rd_issue(input logic [31:0] a);
        int c;
        c = 0;
        model_read(a);
        araddr = a;
        @(negedge clk);
        arvalid = 1;
        while (!arready && c < 20) begin
            @(negedge clk);
            c++;
        end
        chk("ar_accept", arready, 1);
        @(posedge clk);
        @(negedge clk);
        arvalid = 0;
        chk("r_latency", {rvalid, rvalid_r}, 2'b11);
    endtask

    task automatic r_collect();
        logic [33:0] e, er;
        e = exp_r.pop_front();
        er = exp_r_r.pop_front();
        chk("rdata_rresp", {rresp, rdata}, e);
        chk("rdata_rresp_ro", {rresp_r, rdata_r}, er);
        rready = 1;
        @(posedge clk);
        @(negedge clk);
        rready = 0;
        chk("ar_b2b", {rvalid, arready}, 2'b01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_model();
        repeat (3) @(negedge clk);
        chk("reset_ctrl", {awready, wready, arready, bvalid, rvalid}, 5'b0);
        chk("reset_resp", {bresp, rresp, rdata}, 36'h0);
        chk("reset_regs", reg_q, 512'h0);
        rst = 1;
        @(negedge clk);
        chk("ready_rise", {awready, wready, arready}, 3'b111);

        wr_issue(32'h8, 32'hDEADBEEF, 4'hF, 0);
        b_collect();
        rd_issue(32'h8);
        r_collect();

        wr_issue(32'h4, 32'h11223344, 4'hF, 3);
        b_collect();
        wr_issue(32'h4, 32'h0000AA00, 4'h2, 0);
        b_collect();
        rd_issue(32'h4);
        r_collect();

        wr_issue(32'h40, 32'h12345678, 4'hF, 0);
        b_collect();
        wr_issue(32'h6, 32'h12345678, 4'hF, 0);
        b_collect();
        wr_issue(32'h8, 32'h0, 4'h0, 0);
        b_collect();
        rd_issue(32'h40);
        r_collect();

        wr_issue(32'h0, 32'hFFFFFFFF, 4'hF, 0);
        b_collect();
        rd_issue(32'h0);
        r_collect();

        // write and read of the same register on one edge
        @(negedge clk);
        awaddr = 32'h10;
        wdata = 32'hCAFEF00D;
        wstrb = 4'hF;
        araddr = 32'h10;
        model_read(32'h10);
        model_write(32'h10, 32'hCAFEF00D, 4'hF);
        awvalid = 1;
        wvalid = 1;
        arvalid = 1;
        chk("same_edge_ready", {awready, wready, arready}, 3'b111);
        @(posedge clk);
        @(negedge clk);
        {awvalid, wvalid, arvalid} = 3'b000;
        chk("same_edge_valid", {bvalid, rvalid}, 2'b11);
        b_collect();
        r_collect();
        rd_issue(32'h10);
        r_collect();

        wr_issue(32'hC, 32'h0BADF00D, 4'hF, 0);
        rd_issue(32'h8);
        awaddr = 32'h14;
        araddr = 32'h18;
        {awvalid, wvalid, arvalid} = 3'b111;
        repeat (5) begin
            @(negedge clk);
            chk("bp_b", {bvalid, bresp}, {1'b1, exp_b[0]});
            chk("bp_r", {rvalid, rresp, rdata}, {1'b1, exp_r[0]});
            chk("bp_ready", {awready, wready, arready}, 3'b000);
        end
        {awvalid, wvalid, arvalid} = 3'b000;
        b_collect();
        r_collect();

        rd_issue(32'h8);
        awaddr = 32'h18;
        awvalid = 1;
        @(posedge clk);
        @(negedge clk);
        awvalid = 0;
        chk("mid_aw_taken", {awready, wready, rvalid}, 3'b011);
        rst = 0;
        #1;
        chk("async_drop", {bvalid, rvalid, bvalid_r, rvalid_r}, 4'b0);
        chk("reset_ready", {awready, wready, arready}, 3'b000);
        void'(exp_r.pop_front());
        void'(exp_r_r.pop_front());
        clear_model();
        @(negedge clk);
        chk("mid_reset_regs", reg_q, flat(0));
        chk("mid_reset_regs_ro", reg_q_r, flat(1));
        @(negedge clk);
        rst = 1;
        wr_issue(32'h18, 32'h55AA55AA, 4'hF, 0);
        b_collect();
        rd_issue(32'h18);
        r_collect();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi_lite_slave_regs.md
# axi_lite_slave_regs

Parametrised AXI4-Lite slave register bank that terminates the five AXI-Lite channels driven by the write and read drivers on the bus interface. It accepts write address and write data independently and in either order, applies byte strobes, and returns OKAY or SLVERR responses. It serves registered reads with one-cycle latency and exposes the register contents to the surrounding design. A read-only mask gives it a mode the bare bus interface does not have.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; must be 32 or 64
- NUM_REGS, 16, number of registers; must be ≥2
- BASE_ADDR, 0, byte address of register 0; aligned to DATA_W/8
- RO_MASK, 0, NUM_REGS-bit mask; bit i set means register i is read-only to the bus
- clk  in  1  single clock, rising edge
- rst  in  1  reset; asynchronous assert, active-low (0 = reset)
- awvalid/awready  in/out  1  write address handshake
- awaddr  in  ADDR_W  write byte address
- awprot  in  3  ignored
- wvalid/wready  in/out  1  write data handshake
- wdata  in  DATA_W  write data
- wstrb  in  DATA_W/8  byte enables
- bvalid/bready  out/in  1  write response handshake
- bresp  out  2  write response
- arvalid/arready  in/out  1  read address handshake
- araddr  in  ADDR_W  read byte address
- arprot  in  3  ignored
- rvalid/rready  out/in  1  read data handshake
- rdata  out  DATA_W  read data
- rresp  out  2  read response
- reg_q  out  NUM_REGS*DATA_W  flattened register contents; register i is at [i*DATA_W +: DATA_W]

## Operation
- Decode: an address is valid if addr ≥ BASE_ADDR, its low log2(DATA_W/8) bits are 0, and idx = (addr−BASE_ADDR)>>log2(DATA_W/8) is < NUM_REGS.
- Write FSM states and transitions:
  - W_IDLE: awready=1, wready=1. AW handshake only → W_ADDR. W handshake only → W_DATA. Both in the same cycle → W_RESP.
  - W_ADDR: wready=1 only. W handshake → W_RESP.
  - W_DATA: awready=1 only. AW handshake → W_RESP.
  - W_RESP: bvalid=1, no ready asserted. bready → W_IDLE.
- Commit happens on the clock edge that enters W_RESP.
  - Valid address and RO_MASK[idx]=0: each byte lane with wstrb[k]=1 is updated; bresp=OKAY.
  - Invalid address or RO_MASK[idx]=1: no register changes; bresp=SLVERR.
  - wstrb=0 on a valid address: no change; bresp=OKAY.
- Only one write is outstanding at a time.
- Read FSM states and transitions:
  - R_IDLE: arready=1. AR handshake latches rdata and rresp → R_DATA.
  - R_DATA: rvalid=1, arready=0. rready → R_IDLE.
- Read response: valid address gives rdata=reg[idx], rresp=OKAY. Invalid address gives rdata=0, rresp=SLVERR.
- RO registers read normally and stay at their reset value, which is 0.
- Read and write channels operate fully in parallel.

## Timing
- Reset values: all registers 0; awready=0, wready=0, arready=0, bvalid=0, rvalid=0; bresp, rresp, rdata all 0; both FSMs in IDLE. Ready signals rise in the first cycle after rst deasserts.
- Reset asserted mid-transaction: in-flight transactions are dropped, all valid signals drop immediately (asynchronously), and no partial commit occurs.
- Write latency: bvalid rises the cycle after the last of AW/W handshakes.
- Read latency: rvalid rises the cycle after the AR handshake.
- bvalid, bresp, rvalid, rdata and rresp are held stable until their handshake completes, regardless of other activity.
- Read and write commit on the same register at the same edge: the read returns the pre-write value.
- reg_q reflects a commit on the cycle after the commit edge.
- Back-to-back reads: the next AR handshake is possible the cycle after the R handshake, so peak throughput is one read per 2 cycles.

## Structure
- Package axi_lite_pkg holds:
  - resp_t enum: OKAY=2'b00, SLVERR=2'b10
  - wr_state_t {W_IDLE, W_ADDR, W_DATA, W_RESP}
  - rd_state_t {R_IDLE, R_DATA}
- Sub-module axi_lite_decode (combinational): address → idx plus valid flag. It is instantiated twice, once for AW and once for AR.
- Register array, write FSM and read FSM live in axi_lite_slave_regs.

## Test plan
- Write then read, default parameters: AW and W in the same cycle with awaddr=0x8, wdata=0xDEADBEEF, wstrb=0xF → bresp=OKAY one cycle later. AR 0x8 → rdata=0xDEADBEEF, rresp=OKAY, one cycle after AR.
- W before AW: W wdata=0x11223344 at cycle 0, AW 0x4 at cycle 3 → awready=1 and wready=0 during cycles 1-3, bvalid at cycle 4. Then wstrb=0x2 with wdata=0x0000AA00 → register reads 0x1122AA44.
- Errors: AW 0x40 (idx 16) → SLVERR, reg_q unchanged. AW 0x6 (misaligned) → SLVERR. AR 0x40 → rdata=0, rresp=SLVERR.
- Read-only register: with RO_MASK=16'h0001, write 0xFFFFFFFF to address 0x0 → SLVERR; register reads 0.
- Backpressure: hold bready=0 and rready=0 for 5 cycles → bvalid/bresp and rvalid/rdata remain stable; awready, wready and arready remain 0.
- Reset mid-transaction: after the AW handshake with no W, drive rst=0 for 2 cycles → all valids 0, registers 0; a fresh write after release completes with OKAY.
